// File: rtl/drfm_pkg.sv
// Shared types for the SDRAM capture path: FSM states, address width
// and the packed word-FIFO entry.
package drfm_pkg;

    localparam int SDRAM_ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } cap_state_e;

    typedef struct packed {
        logic [1:0]  byteenable;
        logic [15:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead synchronous FIFO of packed capture words.
// Writes are accepted when full only if a read frees a slot that cycle.
module capture_fifo
    import drfm_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_wr,
    input  fifo_entry_t i_data,
    input  logic        i_rd,
    output fifo_entry_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    fifo_entry_t r_mem [2**AW];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        w_do_rd;
    logic        w_do_wr;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_do_rd = i_rd & ~o_empty;
    assign w_do_wr = i_wr & (~o_full | w_do_rd);
    assign o_head  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wp[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (i_clr) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_wr) r_wp <= r_wp + 1'b1;
            if (w_do_rd) r_rp <= r_rp + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_capture_writer.sv
// Avalon-MM write master packing byte samples into 16-bit SDRAM words.
// Define CAPTURE_WRAP_EN for circular recording until abort.
module sdram_capture_writer
    import drfm_pkg::*;
#(
    parameter int                ADDR_W  = SDRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] CAP_LEN = 25'd1048576,
    parameter int                FIFO_AW = 4
) (
    input  logic              M100CLK,
    input  logic              lock,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        sample_in,
    input  logic              sample_valid,
    output logic [ADDR_W-1:0] avm_address,
    output logic [1:0]        avm_byteenable,
    output logic              avm_write,
    output logic [15:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_written
);

    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST = CAP_LEN - ONE;

    logic [1:0]        r_sync;
    logic              w_rst_n;
    cap_state_e        r_state;
    logic              r_pend;
    logic [7:0]        r_lo;
    logic              r_push;
    fifo_entry_t       r_push_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_ww;
    logic [1:0]        r_be;
    logic [15:0]       r_data;
    logic              r_wr;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;
`ifdef CAPTURE_WRAP_EN
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_wcnt;
`else
    logic [ADDR_W-1:0] r_push_cnt;
`endif

    fifo_entry_t w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_arm;
    logic        w_xfer;
    logic        w_pop;

    // Reset asserts asynchronously but releases on a clock edge
    always_ff @(posedge M100CLK or negedge lock) begin
        if (!lock) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], 1'b1};
    end
    assign w_rst_n = r_sync[1];

    assign w_arm  = arm & ((r_state == IDLE) | (r_state == DONE));
    assign w_xfer = r_wr & ~avm_waitrequest;
    assign w_pop  = ~w_empty & (~r_wr | w_xfer);

    capture_fifo #(.AW(FIFO_AW)) u_fifo (
        .i_clk   (M100CLK),
        .i_rst_n (w_rst_n),
        .i_clr   (w_arm),
        .i_wr    (r_push),
        .i_data  (r_push_d),
        .i_rd    (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge M100CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= IDLE;
            r_pend   <= 1'b0;
            r_lo     <= '0;
            r_push   <= 1'b0;
            r_push_d <= '0;
            r_addr   <= '0;
            r_ww     <= '0;
            r_be     <= '0;
            r_data   <= '0;
            r_wr     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef CAPTURE_WRAP_EN
            r_base   <= '0;
            r_wcnt   <= '0;
`else
            r_push_cnt <= '0;
`endif
        end else begin
            r_push <= 1'b0;
            if (w_arm) begin
                r_state <= CAPTURE;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_pend  <= 1'b0;
                r_ovf   <= 1'b0;
                r_ww    <= '0;
                r_addr  <= base_addr;
`ifdef CAPTURE_WRAP_EN
                r_base  <= base_addr;
                r_wcnt  <= '0;
`else
                r_push_cnt <= '0;
`endif
            end else begin
                unique case (r_state)
                    CAPTURE: begin
                        if (abort) begin
                            r_state <= DRAIN;
                            r_pend  <= 1'b0;
                            if (r_pend) begin
                                r_push   <= 1'b1;
                                r_push_d <= {2'b01, 8'h00, r_lo};
                            end
                        end else if (sample_valid) begin
                            if (r_pend) begin
                                r_pend   <= 1'b0;
                                r_push   <= 1'b1;
                                r_push_d <= {2'b11, sample_in, r_lo};
`ifndef CAPTURE_WRAP_EN
                                r_push_cnt <= r_push_cnt + ONE;
                                if (r_push_cnt == LAST) r_state <= DRAIN;
`endif
                            end else begin
                                r_lo   <= sample_in;
                                r_pend <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!r_push && w_empty && !r_wr) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                // A pop in the same cycle frees the slot, so only then is it safe
                if (r_push && w_full && !w_pop) r_ovf <= 1'b1;

                if (w_xfer) begin
`ifdef CAPTURE_WRAP_EN
                    if (r_wcnt == LAST) begin
                        r_wcnt <= '0;
                        r_addr <= r_base;
                    end else begin
                        r_wcnt <= r_wcnt + ONE;
                        r_addr <= r_addr + ONE;
                    end
                    if (r_ww != CAP_LEN) r_ww <= r_ww + ONE;
`else
                    r_addr <= r_addr + ONE;
                    r_ww   <= r_ww + ONE;
`endif
                end

                if (w_pop) begin
                    r_wr   <= 1'b1;
                    r_be   <= w_head.byteenable;
                    r_data <= w_head.data;
                end else if (w_xfer) begin
                    r_wr <= 1'b0;
                end
            end
        end
    end

    assign avm_address    = r_addr;
    assign avm_byteenable = r_be;
    assign avm_write      = r_wr;
    assign avm_writedata  = r_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow       = r_ovf;
    assign words_written  = r_ww;

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Scoreboard bench for sdram_capture_writer: random byte streams and
// waitrequest, expected writes queued from a byte-level capture model.
module tb_sdram_capture_writer;

    localparam int AW  = 25;
    localparam int CAP = 20;
`ifdef CAPTURE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          lock = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          avm_waitrequest = 1'b0;
    logic [AW-1:0] avm_address;
    logic [1:0]    avm_byteenable;
    logic          avm_write;
    logic [15:0]   avm_writedata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW-1:0] words_written;

    always #5 clk = ~clk;

    sdram_capture_writer #(
        .ADDR_W  (AW),
        .CAP_LEN (25'd20),
        .FIFO_AW (4)
    ) dut (
        .M100CLK         (clk),
        .lock            (lock),
        .arm             (arm),
        .abort           (abort),
        .base_addr       (base_addr),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .words_written   (words_written)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [1:0]    be;
        logic [15:0]   d;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] stim[$];
    int         errs = 0;
    int         checks = 0;
    int         wr_mode = 0;

    // 0: always ready, 1: random stalls, 2: stall continuously
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            0:       avm_waitrequest = 1'b0;
            1:       avm_waitrequest = ($urandom_range(3) == 0);
            default: avm_waitrequest = 1'b1;
        endcase
    end

    // Outputs must match the queue head for every cycle avm_write is high
    always @(negedge clk) begin
        if (avm_write) begin
            checks++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL write_unexpected got a=%h be=%b d=%h",
                         avm_address, avm_byteenable, avm_writedata);
            end else begin
                if ({avm_address, avm_byteenable, avm_writedata} !== sbq[0]) begin
                    errs++;
                    $display("FAIL write got a=%h be=%b d=%h want a=%h be=%b d=%h",
                             avm_address, avm_byteenable, avm_writedata,
                             sbq[0].a, sbq[0].be, sbq[0].d);
                end
                if (!avm_waitrequest) void'(sbq.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [AW-1:0] base, inout int stored,
                               input int keep_max, input logic [1:0] be,
                               input logic [15:0] d);
        exp_t e;
        if (stored < keep_max) begin
            e.a  = base + AW'(WRAP ? (stored % CAP) : stored);
            e.be = be;
            e.d  = d;
            sbq.push_back(e);
            stored++;
        end
    endtask

    task automatic run_capture(input logic [AW-1:0] base, input int mode,
                               input bit gaps, input int keep_max,
                               input bit exp_ovf, input bit arm_abort);
        int         words = 0;
        int         stored = 0;
        int         eww;
        int         c = 0;
        bit         pend = 0;
        bit         cap = 1;
        logic [7:0] lo = '0;
        wr_mode = mode;
        sample_valid = 1'b1;
        sample_in = 8'hEE;
        tick();
        sample_valid = 1'b0;
        arm = 1'b1;
        abort = arm_abort;
        base_addr = base;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        chk("busy_after_arm", 32'(busy), 32'd1);
        chk("done_after_arm", 32'(done), 32'd0);
        foreach (stim[i]) begin
            if (gaps) repeat ($urandom_range(1)) tick();
            sample_valid = 1'b1;
            sample_in = stim[i];
            tick();
            sample_valid = 1'b0;
            if (cap) begin
                if (pend) begin
                    expect_word(base, stored, keep_max, 2'b11, {stim[i], lo});
                    pend = 0;
                    words++;
                    if (!WRAP && words == CAP) cap = 0;
                end else begin
                    lo = stim[i];
                    pend = 1;
                end
            end
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (cap && pend) expect_word(base, stored, keep_max, 2'b01, {8'h00, lo});
        if (mode == 2) wr_mode = 0;
        while (!done && c < 3000) begin
            tick();
            c++;
        end
        eww = (WRAP && stored > CAP) ? CAP : stored;
        chk("done_reached", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("words_written", 32'(words_written), 32'(eww));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        sbq.delete();
    endtask

    task automatic rand_stim(input int n);
        stim.delete();
        repeat (n) stim.push_back(8'($urandom));
    endtask

    initial begin
        int   c;
        exp_t e;
        #1 lock = 1'b0;
        #3;
        chk("rst_address", 32'(avm_address), 32'd0);
        chk("rst_be", 32'(avm_byteenable), 32'd0);
        chk("rst_wdata", 32'(avm_writedata), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        repeat (3) tick();
        lock = 1'b1;
        repeat (3) tick();

        stim.delete();
        for (int i = 1; i <= 40; i++) stim.push_back(8'(i));
        run_capture(25'h100, 0, 0, 1000, 0, 0);

        stim.delete();
        stim.push_back(8'hAA);
        stim.push_back(8'hBB);
        stim.push_back(8'hCC);
        run_capture(25'($urandom), 0, 1, 1000, 0, 1);

        // Stalled writer holds one word plus a full 16-entry FIFO
        rand_stim(40);
        run_capture(25'($urandom), 2, 0, 17, 1, 1);

        for (int r = 0; r < 6; r++) begin
            rand_stim($urandom_range(50, 1));
            run_capture((r == 2) ? 25'h1FF_FFFD : 25'($urandom), 1, 1, 1000, 0, 1);
        end

        wr_mode = 2;
        arm = 1'b1;
        base_addr = 25'h0AB_CDE;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_in = 8'(8'h10 + i);
            tick();
        end
        sample_valid = 1'b0;
        e.a = 25'h0AB_CDE;
        e.be = 2'b11;
        e.d = 16'h1110;
        sbq.push_back(e);
        c = 0;
        while (!avm_write && c < 50) begin
            tick();
            c++;
        end
        chk("stall_write_seen", 32'(avm_write), 32'd1);
        #2 lock = 1'b0;
        #1;
        sbq.delete();
        chk("midrst_write", 32'(avm_write), 32'd0);
        chk("midrst_address", 32'(avm_address), 32'd0);
        chk("midrst_wdata", 32'(avm_writedata), 32'd0);
        chk("midrst_be", 32'(avm_byteenable), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        lock = 1'b1;
        wr_mode = 0;
        repeat (3) tick();
        rand_stim(6);
        run_capture(25'h0AB_CDE, 0, 1, 1000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
